// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the FPU datapath: field widths, special
// encodings, divider state encoding and the one-hot result class record.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int FRAC_W  = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    localparam logic [15:0] QNAN_CANON = 16'h7E00;
    localparam logic [15:0] POS_INF    = 16'h7C00;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIV,
        NORM,
        DONE
    } div_state_t;

    typedef struct packed {
        logic snan;
        logic qnan;
        logic inf;
        logic zero;
        logic subnormal;
        logic normal;
    } fp_cls_t;

endpackage

// File: rtl/fp_class.sv
// Binary16 operand classifier: one-hot class of a value plus its sign bit.
module fp_class
    import fp16_pkg::*;
(
    input  logic [15:0] f,
    output fp_cls_t     cls,
    output logic        neg
);

    logic [EXP_W-1:0]  ex;
    logic [FRAC_W-1:0] fr;

    always_comb begin
        cls = '0;
        neg = f[15];
        ex  = f[14:10];
        fr  = f[9:0];
        if (ex == EXP_W'(EXP_MAX)) begin
            if (fr == '0)
                cls.inf = 1'b1;
            else if (fr[FRAC_W-1])
                cls.qnan = 1'b1;
            else
                cls.snan = 1'b1;
        end else if (ex == '0) begin
            if (fr == '0)
                cls.zero = 1'b1;
            else
                cls.subnormal = 1'b1;
        end else begin
            cls.normal = 1'b1;
        end
    end

endmodule

// File: rtl/fp16_div.sv
// Sequential binary16 divider (restoring radix-2, 13 quotient bits), one
// operation in flight. Define FP16_DIV_RNE_EN for round-to-nearest-even.
module fp16_div
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic        sNaN_o,
    output logic        qNaN_o,
    output logic        infinity_o,
    output logic        zero_o,
    output logic        subnormal_o,
    output logic        normal_o
);

    localparam int ITER = 13;
`ifdef FP16_DIV_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif
    localparam logic signed [6:0] E_INF = 7'(EXP_MAX);

    // Round-up decision; in the truncating build RNE is 0 and this folds away.
    function automatic logic rnd_inc(input logic g, input logic s, input logic lsb);
        return RNE & g & (s | lsb);
    endfunction

    div_state_t state, state_nx;
    logic [3:0] cnt;

    logic [15:0] a_p0, b_p0;
    fp_cls_t     a_cls, b_cls;
    logic        a_neg, b_neg, a_z, b_z;

    logic               sign_p1;
    logic signed [6:0]  e_p1;
    logic [10:0]        sb_p1;
    logic [12:0]        rem_p1, quo_p1;

    logic        spec_hit;
    logic [15:0] spec_q;
    fp_cls_t     spec_cls;

    logic [12:0] rem_sub, rem_nx;
    logic        rem_ge;

    logic signed [6:0] e_n, e_r;
    logic [6:0]        shm1;
    logic [9:0]        mant;
    logic              guard, sticky;
    logic [21:0]       ext;
    logic [10:0]       m_nrm, m_sub;
    logic [15:0]       norm_q;
    fp_cls_t           norm_cls;

    logic [15:0] q_r;
    fp_cls_t     cls_r;

    fp_class u_cls_a (.f(a_p0), .cls(a_cls), .neg(a_neg));
    fp_class u_cls_b (.f(b_p0), .cls(b_cls), .neg(b_neg));

    // Subnormal operands are treated as zero.
    assign a_z = a_cls.zero | a_cls.subnormal;
    assign b_z = b_cls.zero | b_cls.subnormal;

    always_comb begin
        spec_hit = 1'b1;
        spec_q   = '0;
        spec_cls = '0;
        if (a_cls.normal && b_cls.normal) begin
            spec_hit = 1'b0;
        end else if (a_cls.snan || b_cls.snan) begin
            spec_q        = a_cls.snan ? a_p0 : b_p0;
            spec_cls.snan = 1'b1;
        end else if (a_cls.qnan || b_cls.qnan) begin
            spec_q        = a_cls.qnan ? a_p0 : b_p0;
            spec_cls.qnan = 1'b1;
        end else if ((a_cls.inf && b_cls.inf) || (a_z && b_z)) begin
            spec_q        = QNAN_CANON;
            spec_cls.qnan = 1'b1;
        end else if (a_cls.inf || b_z) begin
            spec_q       = {a_neg ^ b_neg, POS_INF[14:0]};
            spec_cls.inf = 1'b1;
        end else begin
            spec_q        = {a_neg ^ b_neg, 15'h0};
            spec_cls.zero = 1'b1;
        end
    end

    assign rem_ge  = rem_p1 >= {2'b00, sb_p1};
    assign rem_sub = rem_p1 - {2'b00, sb_p1};
    assign rem_nx  = rem_ge ? rem_sub : rem_p1;

    always_comb begin
        e_n    = quo_p1[12] ? e_p1 : e_p1 - 7'sd1;
        mant   = quo_p1[12] ? quo_p1[11:2] : quo_p1[10:1];
        guard  = quo_p1[12] ? quo_p1[1] : quo_p1[0];
        sticky = (|rem_p1) | (quo_p1[12] & quo_p1[0]);
        // Denormalising shift beyond the first position (hidden bit lands in ext[21] at shm1=0).
        shm1   = 7'(-e_n);
        ext    = {1'b1, mant, guard, 10'b0} >> shm1;
        m_nrm  = {1'b0, mant} + {10'b0, rnd_inc(guard, sticky, mant[0])};
        e_r    = e_n + $signed({6'b0, m_nrm[10]});
        m_sub  = {1'b0, ext[21:12]}
               + {10'b0, rnd_inc(ext[11], (|ext[10:0]) | sticky, ext[12])};
        norm_q   = '0;
        norm_cls = '0;
        if (e_n >= E_INF) begin
            norm_q       = {sign_p1, POS_INF[14:0]};
            norm_cls.inf = 1'b1;
        end else if (e_n >= 7'sd1) begin
            if (e_r >= E_INF) begin
                norm_q       = {sign_p1, POS_INF[14:0]};
                norm_cls.inf = 1'b1;
            end else begin
                norm_q          = {sign_p1, e_r[4:0], m_nrm[9:0]};
                norm_cls.normal = 1'b1;
            end
        end else if (shm1 > 7'd10) begin
            norm_q        = {sign_p1, 15'h0};
            norm_cls.zero = 1'b1;
        end else begin
            norm_q = {sign_p1, 4'b0, m_sub};
            if (m_sub[10])
                norm_cls.normal = 1'b1;
            else if (m_sub == '0)
                norm_cls.zero = 1'b1;
            else
                norm_cls.subnormal = 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = PREP;
            PREP:    state_nx = spec_hit ? DONE : DIV;
            DIV:     if (cnt == '0) state_nx = NORM;
            NORM:    state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == PREP)
                cnt <= 4'(ITER - 1);
            else if (state == DIV)
                cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            // p0: operand capture
            IDLE: begin
                if (in_valid) begin
                    a_p0 <= op_a;
                    b_p0 <= op_b;
                end
            end
            // p1: exponent difference and significand setup
            PREP: begin
                sign_p1 <= a_neg ^ b_neg;
                e_p1    <= $signed({2'b00, a_p0[14:10]}) - $signed({2'b00, b_p0[14:10]})
                           + 7'(BIAS);
                sb_p1   <= {1'b1, b_p0[9:0]};
                rem_p1  <= {2'b00, 1'b1, a_p0[9:0]};
                quo_p1  <= '0;
                q_r     <= spec_q;
                cls_r   <= spec_cls;
            end
            DIV: begin
                quo_p1 <= {quo_p1[11:0], rem_ge};
                rem_p1 <= rem_nx << 1;
            end
            // p2: normalise, round, pack
            NORM: begin
                q_r   <= norm_q;
                cls_r <= norm_cls;
            end
            default: ;
        endcase
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign q           = out_valid ? q_r : 16'h0;
    assign sNaN_o      = out_valid & cls_r.snan;
    assign qNaN_o      = out_valid & cls_r.qnan;
    assign infinity_o  = out_valid & cls_r.inf;
    assign zero_o      = out_valid & cls_r.zero;
    assign subnormal_o = out_valid & cls_r.subnormal;
    assign normal_o    = out_valid & cls_r.normal;

endmodule

// File: tb/tb_fp16_div.sv
// Testbench for fp16_div: vector table through a scoreboard queue, plus
// back-pressure and mid-operation reset sequences.
module tb_fp16_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] op_a = 16'h0;
    logic [15:0] op_b = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] q;
    logic        sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o;

    localparam logic [5:0] C_SN  = 6'b100000;
    localparam logic [5:0] C_QN  = 6'b010000;
    localparam logic [5:0] C_INF = 6'b001000;
    localparam logic [5:0] C_Z   = 6'b000100;
    localparam logic [5:0] C_SUB = 6'b000010;
    localparam logic [5:0] C_NRM = 6'b000001;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [5:0]  cls;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [5:0]  cls;
        int          lat;
        int          acc;
    } exp_t;

    vec_t vecs[18];
    exp_t sb[$];
    bit   seen = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [5:0] fl;

    fp16_div dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .q(q),
        .sNaN_o(sNaN_o), .qNaN_o(qNaN_o), .infinity_o(infinity_o),
        .zero_o(zero_o), .subnormal_o(subnormal_o), .normal_o(normal_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign fl = {sNaN_o, qNaN_o, infinity_o, zero_o, subnormal_o, normal_o};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Output monitor: compares every valid cycle against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got q=%h with empty scoreboard", q);
                end else begin
                    if (!seen) begin
                        check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                        seen = 1'b1;
                    end
                    check("q", {16'h0, q}, {16'h0, sb[0].q});
                    check("class", {26'h0, fl}, {26'h0, sb[0].cls});
                    check("in_ready_busy", {31'h0, in_ready}, 32'h0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end else begin
                check("flags_idle", {26'h0, fl}, 32'h0);
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [5:0] ec, input int lat);
        int t;
        exp_t e;
        t = 0;
        @(posedge clk);
        #1;
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: in_ready stayed 0 for op %h/%h", a, b);
                in_valid = 1'b0;
                return;
            end
        end
        e.q = eq;
        e.cls = ec;
        e.lat = lat;
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0) begin
            @(posedge clk);
            t++;
            if (t > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain_timeout: %0d results outstanding, got 0 required", sb.size());
                sb.delete();
                seen = 1'b0;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{16'h3C00, 16'h3C00, 16'h3C00, C_NRM, 15};
        vecs[1]  = '{16'h4600, 16'h4200, 16'h4000, C_NRM, 15};
        vecs[2]  = '{16'h3C00, 16'h4200, 16'h3555, C_NRM, 15};
        vecs[3]  = '{16'h3C00, 16'h0000, 16'h7C00, C_INF, 1};
        vecs[4]  = '{16'h0000, 16'h0000, 16'h7E00, C_QN,  1};
        vecs[5]  = '{16'h7D00, 16'h3C00, 16'h7D00, C_SN,  1};
        vecs[6]  = '{16'h0400, 16'h4000, 16'h0200, C_SUB, 15};
        vecs[7]  = '{16'h7BFF, 16'h0400, 16'h7C00, C_INF, 15};
        vecs[8]  = '{16'hC400, 16'h4000, 16'hC000, C_NRM, 15};
        vecs[9]  = '{16'h0001, 16'h3C00, 16'h0000, C_Z,   1};
        vecs[10] = '{16'h7C00, 16'h7C00, 16'h7E00, C_QN,  1};
        vecs[11] = '{16'h7E00, 16'h7D00, 16'h7D00, C_SN,  1};
        vecs[12] = '{16'h7E01, 16'h3C00, 16'h7E01, C_QN,  1};
        vecs[13] = '{16'h3C00, 16'h7C00, 16'h0000, C_Z,   1};
        vecs[14] = '{16'h7C00, 16'hC000, 16'hFC00, C_INF, 1};
        vecs[15] = '{16'h0400, 16'h7800, 16'h0000, C_Z,   15};
        vecs[16] = '{16'h8000, 16'h3C00, 16'h8000, C_Z,   1};
        vecs[17] = '{16'h3C00, 16'h3E00, 16'h3955, C_NRM, 15};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_q", {16'h0, q}, 32'h0);
        check("rst_flags", {26'h0, fl}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].cls, vecs[i].lat);
            drain();
        end

        // Back-pressure: result held while out_ready=0
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(16'h4600, 16'h4200, 16'h4000, C_NRM, 15);
        begin
            int t;
            t = 0;
            while (!out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("hold_reached_valid", {31'h0, out_valid}, 32'h1);
        end
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release_out_valid", {31'h0, out_valid}, 32'h0);
        check("release_in_ready", {31'h0, in_ready}, 32'h1);
        drain();

        // Reset in the middle of a divide aborts it
        issue(16'h4600, 16'h4200, 16'h4000, C_NRM, 15);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        seen = 1'b0;
        @(negedge clk);
        check("abort_out_valid", {31'h0, out_valid}, 32'h0);
        check("abort_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_abort_in_ready", {31'h0, in_ready}, 32'h1);
        issue(16'h4000, 16'h4000, 16'h3C00, C_NRM, 15);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
